serial_add_sub: RTL and testbench

- Parametrised, multi-cycle signed adder/subtractor; next generation of the fixed 3-bit combinational add/sub in the signed calculator datapath.
- Processes WIDTH-bit two's-complement operands one bit per clock through a single full-adder slice with a registered carry.
- Produces:
  - the exact (WIDTH+1)-bit signed result;
  - its sign-magnitude form for the display path;
  - a WIDTH-bit overflow flag.
- Uses valid/ready handshakes on both input and output sides.

---
 rtl/serial_add_sub.sv | 197 +++++++++++++++++++
 tb/tb_serial_add_sub.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial signed adder/subtractor.
//
// This block computes A+B or A-B on WIDTH-bit two's-complement operands. It
// handles one bit per clock, using a single full-adder slice with a registered
// carry. The result is exact and WIDTH+1 bits wide, so it never wraps.
//
// Besides the result, the block also produces:
//   - the magnitude and sign of the result, for the display path;
//   - a flag that is set when the result does not fit in WIDTH signed bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands and mode valid (accepted only in IDLE)
//   in_ready   high only in IDLE
//   a, b       signed WIDTH-bit operands
//   sub        0: a+b, 1: a-b
//   out_valid  result outputs valid (DONE)
//   out_ready  consumer accepts result (honoured only in DONE)
//   result     exact signed result, WIDTH+1 bits
//   magnitude  absolute value of result, WIDTH+1 bits
//   sign       1 when result is negative
//   overflow   result not representable in WIDTH signed bits
//   busy       high while the operation is in RUN or FIX
//
// Timing: operands are accepted at edge E0. out_valid rises after edge
// E(WIDTH+1). Result outputs hold their values until the next FIX edge.
module serial_add_sub #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   result,
    output logic [WIDTH:0]   magnitude,
    output logic             sign,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operand shift registers. They shift right and replicate the MSB. Once
    // all WIDTH bits have been consumed, bit 0 therefore still holds the
    // operand's sign bit, and the FIX step can reuse the same slice to form
    // the sign-extension bit.
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;

    logic [WIDTH:0]   result_q, result_d;
    logic [WIDTH:0]   magnitude_q, magnitude_d;
    logic             sign_q, sign_d;
    logic             overflow_q, overflow_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    // Full-adder slice
    logic           b_bit;
    logic           sum_bit;
    logic           carry_out;
    logic [WIDTH:0] full_res;

    always_comb begin
        b_bit     = b_sh_q[0] ^ sub_q;
        sum_bit   = a_sh_q[0] ^ b_bit ^ carry_q;
        carry_out = (a_sh_q[0] & b_bit) | (a_sh_q[0] & carry_q) | (b_bit & carry_q);
        // In FIX, sum_bit is the sign-extension bit computed from the MSBs.
        full_res  = {sum_bit, acc_q};
    end

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        magnitude_d = magnitude_q;
        sign_d      = sign_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    sub_d      = sub;
                    // Subtraction is A + ~B + 1; the +1 enters as carry-in.
                    carry_d    = sub;
                    cnt_d      = '0;
                    state_d    = StRun;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            StRun: begin
                carry_d = carry_out;
                acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
                a_sh_d  = {a_sh_q[WIDTH-1], a_sh_q[WIDTH-1:1]};
                b_sh_d  = {b_sh_q[WIDTH-1], b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d    = full_res;
                sign_d      = full_res[WIDTH];
                // |result| <= 2^WIDTH, so WIDTH+1 bits always hold the magnitude.
                magnitude_d = full_res[WIDTH] ? (~full_res + ONE) : full_res;
                overflow_d  = full_res[WIDTH] ^ full_res[WIDTH-1];
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            magnitude_q <= '0;
            sign_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            magnitude_q <= magnitude_d;
            sign_q      <= sign_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign magnitude = magnitude_q;
    assign sign      = sign_q;
    assign overflow  = overflow_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub. It instantiates the block at WIDTH=3 and at WIDTH=8.
module tb_serial_add_sub;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // WIDTH=3 instance
    logic       in_valid3, in_ready3, sub3, out_valid3, out_ready3;
    logic       sign3, overflow3, busy3;
    logic [2:0] a3, b3;
    logic [3:0] result3, magnitude3;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, sub8, out_valid8, out_ready8;
    logic       sign8, overflow8, busy8;
    logic [7:0] a8, b8;
    logic [8:0] result8, magnitude8;

    serial_add_sub #(.WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
        .a(a3), .b(b3), .sub(sub3), .out_valid(out_valid3), .out_ready(out_ready3),
        .result(result3), .magnitude(magnitude3), .sign(sign3),
        .overflow(overflow3), .busy(busy3)
    );

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
        .result(result8), .magnitude(magnitude8), .sign(sign8),
        .overflow(overflow8), .busy(busy8)
    );

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       sub;
        logic [3:0] res;
        logic [3:0] mag;
        logic       sgn;
        logic       ovf;
    } vec3_t;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete WIDTH=3 operation, starting from IDLE, with out_ready held high.
    task automatic run3(input vec3_t v, input string tag);
        int n;
        check({tag, " in_ready"}, 32'(in_ready3), 32'd1);
        a3 = v.a; b3 = v.b; sub3 = v.sub; in_valid3 = 1'b1; out_ready3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        a3 = ~v.a; b3 = ~v.b; sub3 = ~v.sub;
        check({tag, " busy"}, 32'(busy3), 32'd1);
        n = 0;
        while (!out_valid3 && n < 20) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'd4);
        check({tag, " result"}, 32'(result3), 32'(v.res));
        check({tag, " magnitude"}, 32'(magnitude3), 32'(v.mag));
        check({tag, " sign"}, 32'(sign3), 32'(v.sgn));
        check({tag, " overflow"}, 32'(overflow3), 32'(v.ovf));
        tick();
        check({tag, " idle_after"}, 32'({out_valid3, in_ready3}), 32'b01);
    endtask

    // One complete WIDTH=8 operation. Expected values come from the caller.
    // When scramble is set, the inputs change randomly while the operation runs.
    task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [8:0] e_res, input logic [8:0] e_mag,
                        input logic e_sgn, input logic e_ovf, input bit scramble,
                        input string tag);
        int n;
        a8 = x; b8 = y; sub8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 40) begin
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
                in_valid8 = 1'($urandom);
            end
            tick();
            n++;
        end
        in_valid8 = 1'b0;
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " result"}, 32'(result8), 32'(e_res));
        check({tag, " magnitude"}, 32'(magnitude8), 32'(e_mag));
        check({tag, " sign"}, 32'(sign8), 32'(e_sgn));
        check({tag, " overflow"}, 32'(overflow8), 32'(e_ovf));
        tick();
        check({tag, " idle_after"}, 32'(in_ready8), 32'd1);
    endtask

    vec3_t tbl3[11];

    initial begin
        int n;
        int seen;
        int sx, sy, r, m;

        tbl3[0]  = '{3'd3, 3'd3, 1'b0, 4'b0110, 4'd6, 1'b0, 1'b1};  //  3 +  3 =  6
        tbl3[1]  = '{3'b100, 3'd3, 1'b1, 4'b1001, 4'd7, 1'b1, 1'b1}; // -4 -  3 = -7
        tbl3[2]  = '{3'd1, 3'd2, 1'b1, 4'b1111, 4'd1, 1'b1, 1'b0};  //  1 -  2 = -1
        tbl3[3]  = '{3'b100, 3'b100, 1'b0, 4'b1000, 4'd8, 1'b1, 1'b1}; // -4 + -4 = -8
        tbl3[4]  = '{3'd2, 3'b111, 1'b0, 4'b0001, 4'd1, 1'b0, 1'b0}; //  2 + -1 =  1
        tbl3[5]  = '{3'd3, 3'b100, 1'b1, 4'b0111, 4'd7, 1'b0, 1'b1}; //  3 - -4 =  7
        tbl3[6]  = '{3'b111, 3'b111, 1'b0, 4'b1110, 4'd2, 1'b1, 1'b0}; // -1 + -1 = -2
        tbl3[7]  = '{3'd0, 3'd0, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0};  //  0 -  0 =  0
        tbl3[8]  = '{3'b100, 3'b100, 1'b1, 4'b0000, 4'd0, 1'b0, 1'b0}; // -4 - -4 = 0
        tbl3[9]  = '{3'd2, 3'd1, 1'b0, 4'b0011, 4'd3, 1'b0, 1'b0};  //  2 +  1 =  3
        tbl3[10] = '{3'b101, 3'b110, 1'b0, 4'b1011, 4'd5, 1'b1, 1'b1}; // -3 + -2 = -5

        rst = 1'b1;
        in_valid3 = 1'b0; out_ready3 = 1'b0; a3 = '0; b3 = '0; sub3 = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0;
        tick();
        check("reset flags3", 32'({in_ready3, out_valid3, busy3}), 32'b100);
        check("reset outs3", 32'({result3, magnitude3, sign3, overflow3}), 32'd0);
        check("reset flags8", 32'({in_ready8, out_valid8, busy8}), 32'b100);
        tick();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run3(tbl3[i], $sformatf("vec%0d", i));
        end

        // Backpressure: hold out_ready low for 5 cycles while in DONE.
        a3 = 3'd1; b3 = 3'd1; sub3 = 1'b0; in_valid3 = 1'b1; out_ready3 = 1'b0;
        tick();
        in_valid3 = 1'b0;
        n = 0;
        while (!out_valid3 && n < 20) begin
            tick();
            n++;
        end
        check("bp latency", 32'(n), 32'd4);
        for (int i = 0; i < 5; i++) begin
            check("bp hold", 32'({out_valid3, in_ready3, result3}), 32'({2'b10, 4'b0010}));
            if (i == 1) begin
                a3 = 3'b111; b3 = 3'b111; in_valid3 = 1'b1;
            end else begin
                in_valid3 = 1'b0;
            end
            tick();
        end
        check("bp still done", 32'({out_valid3, result3}), 32'({1'b1, 4'b0010}));
        // Queue the next operands (3 - -2 = 5) while releasing the consumer.
        a3 = 3'd3; b3 = 3'b110; sub3 = 1'b1; in_valid3 = 1'b1; out_ready3 = 1'b1;
        tick();
        check("bp idle", 32'({out_valid3, in_ready3, busy3}), 32'b010);
        check("bp result held", 32'(result3), 32'b0010);
        tick();
        in_valid3 = 1'b0;
        check("bp accepted", 32'({in_ready3, busy3}), 32'b01);
        n = 0;
        while (!out_valid3 && n < 20) begin
            tick();
            n++;
        end
        check("bp2 latency", 32'(n), 32'd4);
        check("bp2 outs", 32'({result3, magnitude3, sign3, overflow3}),
              32'({4'b0101, 4'd5, 1'b0, 1'b1}));
        tick();

        // Reset asserted at the second RUN edge aborts the operation.
        a3 = 3'd3; b3 = 3'd2; sub3 = 1'b0; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst flags", 32'({in_ready3, out_valid3, busy3}), 32'b100);
        check("rst outs", 32'({result3, magnitude3, sign3, overflow3}), 32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid3) seen++;
        end
        check("rst no out_valid", 32'(seen), 32'd0);
        run3('{3'd2, 3'b111, 1'b0, 4'b0001, 4'd1, 1'b0, 1'b0}, "post_rst");

        // WIDTH=8 boundary: -128 - 127 = -255
        run8(8'h80, 8'h7f, 1'b1, 9'h101, 9'd255, 1'b1, 1'b1, 1'b0, "w8 min");
        run8(8'h7f, 8'h80, 1'b1, 9'h0ff, 9'd255, 1'b0, 1'b1, 1'b0, "w8 max");
        run8(8'h80, 8'h80, 1'b0, 9'h100, 9'h100, 1'b1, 1'b1, 1'b0, "w8 -256");

        // Random vectors against an integer reference, with the inputs changing during RUN
        for (int i = 0; i < 200; i++) begin
            logic [7:0] x, y;
            logic       s;
            x = 8'($urandom); y = 8'($urandom); s = 1'($urandom);
            sx = int'($signed(x));
            sy = int'($signed(y));
            r = s ? (sx - sy) : (sx + sy);
            m = (r < 0) ? -r : r;
            run8(x, y, s, 9'(r), 9'(m), r < 0, (r > 127) || (r < -128), 1'b1,
                 $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
